// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns the EX/MEM register's load/store controls into a single outstanding
// memory request, stalls the pipeline while the request is in flight, and
// fills the MEM/WB register. Misaligned accesses and requests that are never
// acknowledged set a sticky error flag instead of hanging the pipeline.
module mem_access_ctrl #(
    parameter int TO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,

    // EX/MEM register
    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALURes,
    input  logic [31:0] STVal,
    input  logic [4:0]  deest,

    // Data-memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    // Pipeline control
    output logic        stall,

    // MEM/WB register
    output logic        WB_EN_OUT,
    output logic        MEM_R_EN_OUT,
    output logic [31:0] ALURes_OUT,
    output logic [31:0] MemData_OUT,
    output logic [4:0]  dest_OUT,

    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach TO_CYC-1; one spare value keeps TO_CYC=1 legal.
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          suppress_q, suppress_d;
    logic [31:0]   rbuf_q, rbuf_d;

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          wb_en_q, wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic [31:0]   alu_q, alu_d;
    logic [31:0]   mdata_q, mdata_d;
    logic [4:0]    dest_q, dest_d;

    logic          err_q, err_d;
    logic          stall_c;

    logic          access_pending;
    logic          aligned;

    assign access_pending = MEM_R_EN | MEM_W_EN;
    assign aligned        = (ALURes[1:0] == 2'b00);

    // Next-state, request and MEM/WB loading decisions for the access FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d    = state_q;
        cnt_d      = cnt_q;
        suppress_d = suppress_q;
        rbuf_d     = rbuf_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_d      = alu_q;
        mdata_d    = mdata_q;
        dest_d     = dest_q;
        err_d      = err_q;
        stall_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!access_pending) begin
                    // Plain ALU result passes straight into MEM/WB.
                    wb_en_d    = WB_EN;
                    mem_r_en_d = MEM_R_EN;
                    alu_d      = ALURes;
                    mdata_d    = '0;
                    dest_d     = deest;
                end else if (aligned) begin
                    // Launch the request; writes win when both enables are set.
                    stall_c    = 1'b1;
                    state_d    = BUSY;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    we_d       = MEM_W_EN;
                    addr_d     = ALURes;
                    wdata_d    = STVal;
                    wb_en_d    = 1'b0;
                    mem_r_en_d = 1'b0;
                    alu_d      = '0;
                    mdata_d    = '0;
                    dest_d     = '0;
                end else begin
                    // Misaligned: drop the instruction, flag it, insert a bubble.
                    err_d      = 1'b1;
                    wb_en_d    = 1'b0;
                    mem_r_en_d = 1'b0;
                    alu_d      = '0;
                    mdata_d    = '0;
                    dest_d     = '0;
                end
            end

            BUSY: begin
                stall_c    = 1'b1;
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                alu_d      = '0;
                mdata_d    = '0;
                dest_d     = '0;
                if (mem_ack) begin
                    // Completion takes precedence over a timeout in the same cycle.
                    state_d = DONE;
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    rbuf_d  = we_q ? 32'h0 : mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: retire the instruction without a register write.
                    state_d    = DONE;
                    cnt_d      = '0;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = '0;
                    wdata_d    = '0;
                    rbuf_d     = '0;
                    err_d      = 1'b1;
                    suppress_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                // EX/MEM still holds the access; retire it with the buffered data.
                wb_en_d    = WB_EN & ~suppress_q;
                mem_r_en_d = MEM_R_EN;
                alu_d      = ALURes;
                mdata_d    = rbuf_q;
                dest_d     = deest;
                suppress_d = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is forced low during reset so upstream stages are not frozen.
    assign stall = stall_c & ~rst;

    // State, request and MEM/WB registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of the others, independent of block order.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            suppress_q <= 1'b0;
            rbuf_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_q      <= '0;
            mdata_q    <= '0;
            dest_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            suppress_q <= suppress_d;
            rbuf_q     <= rbuf_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_q      <= alu_d;
            mdata_q    <= mdata_d;
            dest_q     <= dest_d;
            err_q      <= err_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign WB_EN_OUT    = wb_en_q;
    assign MEM_R_EN_OUT = mem_r_en_q;
    assign ALURes_OUT   = alu_q;
    assign MemData_OUT  = mdata_q;
    assign dest_OUT     = dest_q;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl.
// A driver plays the role of the upstream pipeline, a memory responder serves
// requests with planned delays, and a monitor compares retirements in MEM/WB
// against expectations computed per instruction when it is issued.
module tb_mem_access_ctrl;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALURes, STVal;
    logic [4:0]  deest;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        WB_EN_OUT, MEM_R_EN_OUT;
    logic [31:0] ALURes_OUT, MemData_OUT;
    logic [4:0]  dest_OUT;
    logic        mem_err;

    mem_access_ctrl #(.TO_CYC(TO_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN        (WB_EN),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .ALURes       (ALURes),
        .STVal        (STVal),
        .deest        (deest),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .WB_EN_OUT    (WB_EN_OUT),
        .MEM_R_EN_OUT (MEM_R_EN_OUT),
        .ALURes_OUT   (ALURes_OUT),
        .MemData_OUT  (MemData_OUT),
        .dest_OUT     (dest_OUT),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    // Expected retirement as seen in MEM/WB.
    typedef struct {
        logic        wb;
        logic        r;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  dst;
        bit          chk_data;
    } ret_t;

    // Expected memory request plus how the memory will answer it.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;     // BUSY cycle carrying the ack; > TO_CYC means never
        logic [31:0] rdata;
    } plan_t;

    ret_t  exp_q[$];
    plan_t plan_q[$];

    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;
    bit    resp_en = 1'b0;
    bit    resp_active = 1'b0;
    bit    force_ack = 1'b0;
    logic [31:0] force_rdata = 32'h0;
    logic  exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every non-bubble retirement must match the oldest expectation.
    initial begin
        ret_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (WB_EN_OUT === 1'b1 || MEM_R_EN_OUT === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got alu=%h dst=%0d expected none (t=%0t)",
                             ALURes_OUT, dest_OUT, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ret_wb_en", {31'b0, WB_EN_OUT}, {31'b0, e.wb});
                    check("ret_mem_r_en", {31'b0, MEM_R_EN_OUT}, {31'b0, e.r});
                    check("ret_alures", ALURes_OUT, e.alu);
                    check("ret_dest", {27'b0, dest_OUT}, {27'b0, e.dst});
                    if (e.chk_data) check("ret_memdata", MemData_OUT, e.data);
                end
            end
        end
    end

    // Memory responder: checks request fields, acks on the planned cycle,
    // checks request duration, and sprinkles stray acks while idle.
    initial begin
        plan_t cur;
        int    cyc;
        int    exp_len;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        cyc = 0;
        cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, delay: 0, rdata: 32'h0};
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!resp_en) begin
                mem_ack   = force_ack;
                mem_rdata = force_rdata;
            end else if (mem_req === 1'b1) begin
                if (!resp_active) begin
                    resp_active = 1'b1;
                    cyc = 0;
                    if (plan_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got addr=%h expected no request (t=%0t)",
                                 mem_addr, $time);
                        cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata,
                                delay: TO_CYC + 1, rdata: 32'h0};
                    end else begin
                        cur = plan_q.pop_front();
                    end
                end
                check("req_addr", mem_addr, cur.addr);
                check("req_we", {31'b0, mem_we}, {31'b0, cur.we});
                check("req_wdata", mem_wdata, cur.wdata);
                cyc++;
                if (cyc == cur.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                end
            end else begin
                if (resp_active) begin
                    resp_active = 1'b0;
                    exp_len = (cur.delay <= TO_CYC) ? cur.delay : TO_CYC;
                    check("req_duration", cyc, exp_len);
                end
                if ($urandom_range(0, 3) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    task automatic drive_nop();
        WB_EN    = 1'b0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        ALURes   = 32'h0;
        STVal    = 32'h0;
        deest    = 5'd0;
    endtask

    // Present one instruction (called just after a rising edge) and hold it
    // until the controller consumes it. Expectations come from the rules:
    // plain ops retire next edge; aligned accesses stall 1 + wait cycles;
    // misaligned ones are dropped with an error; no ack within TO_CYC cycles
    // retires a suppressed write-back with zero data.
    task automatic issue(input logic wb, input logic r, input logic w,
                         input logic [31:0] alu, input logic [31:0] st,
                         input logic [4:0] dst, input int dly, input logic [31:0] rd);
        bit    access, alig, tmo, s;
        int    exp_stalls, stalls, n;
        ret_t  e;
        plan_t p;
        access = r | w;
        alig   = (alu[1:0] == 2'b00);
        tmo    = access && alig && (dly > TO_CYC);
        if (!access) exp_stalls = 0;
        else if (!alig) exp_stalls = 0;
        else exp_stalls = 1 + ((dly <= TO_CYC) ? dly : TO_CYC);

        if (!access) begin
            if (wb) begin
                e = '{wb: wb, r: 1'b0, alu: alu, data: 32'h0, dst: dst, chk_data: 1'b1};
                exp_q.push_back(e);
            end
        end else if (alig) begin
            p = '{addr: alu, we: w, wdata: st, delay: dly, rdata: rd};
            plan_q.push_back(p);
            e = '{wb: wb & ~tmo, r: r, alu: alu, data: (tmo ? 32'h0 : rd), dst: dst,
                  chk_data: !w};
            if (e.wb || e.r) exp_q.push_back(e);
        end

        WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w;
        ALURes = alu; STVal = st; deest = dst;

        stalls = 0;
        n = 0;
        forever begin
            @(negedge clk);
            s = stall;
            if (tmo && !s) exp_err = 1'b1;
            check("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
            if (s) stalls++;
            @(posedge clk);
            #1;
            if (!s) break;
            n++;
            if (n > TO_CYC + 8) begin
                total++;
                bad++;
                $display("FAIL stall_bound: got stall held %0d cycles expected release (t=%0t)",
                         n, $time);
                break;
            end
        end
        if (access && !alig) exp_err = 1'b1;
        check("stall_cycles", stalls, exp_stalls);
    endtask

    initial begin
        logic        wb, r, w;
        logic [31:0] a, st, rd;
        logic [4:0]  d;
        int          kind, dly;

        // Global watchdog.
        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: got no finish expected finish (t=%0t)", $time);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset while an aligned load is presented: stall must stay low.
        rst = 1'b1;
        WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        ALURes = 32'h100; STVal = 32'h0; deest = 5'd1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_wb_en_out", {31'b0, WB_EN_OUT}, 32'h0);
        check("rst_alures_out", ALURes_OUT, 32'h0);
        check("rst_mem_err", {31'b0, mem_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_nop();
        mon_en  = 1'b1;
        resp_en = 1'b1;

        // Directed: ALU op retires one edge later.
        issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3, 1, 32'h0);
        check("alu_wb_en_out", {31'b0, WB_EN_OUT}, 32'h1);
        check("alu_alures_out", ALURes_OUT, 32'h10);
        check("alu_dest_out", {27'b0, dest_OUT}, 32'd3);

        // Directed: load 0x40, ack on 3rd BUSY cycle (4 stall cycles).
        issue(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 3, 32'hCAFEF00D);
        check("ld_memdata_out", MemData_OUT, 32'hCAFEF00D);
        check("ld_mem_r_en_out", {31'b0, MEM_R_EN_OUT}, 32'h1);

        // Directed: store 0x8 / 0x55, ack in 1st BUSY cycle, retires without write-back.
        issue(1'b0, 1'b0, 1'b1, 32'h8, 32'h55, 5'd4, 1, 32'h0);
        check("st_wb_en_out", {31'b0, WB_EN_OUT}, 32'h0);

        // Directed: misaligned load 0x41 is dropped with an error.
        issue(1'b1, 1'b1, 1'b0, 32'h41, 32'h0, 5'd5, 1, 32'h0);
        check("mis_mem_err", {31'b0, mem_err}, 32'h1);
        check("mis_wb_en_out", {31'b0, WB_EN_OUT}, 32'h0);
        check("mis_mem_r_en_out", {31'b0, MEM_R_EN_OUT}, 32'h0);

        // Directed: load never acknowledged times out.
        issue(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6, TO_CYC + 4, 32'h12345678);
        check("tmo_wb_en_out", {31'b0, WB_EN_OUT}, 32'h0);
        check("tmo_memdata_out", MemData_OUT, 32'h0);

        // Randomized mix of ALU ops, loads, stores and misaligned accesses.
        for (int i = 0; i < 160; i++) begin
            kind = $urandom_range(0, 99);
            wb   = 1'($urandom_range(0, 1));
            st   = $urandom;
            d    = 5'($urandom_range(0, 31));
            rd   = $urandom;
            a    = $urandom;
            dly  = ($urandom_range(0, 9) == 0) ? TO_CYC + 3 : $urandom_range(1, 4);
            if (kind < 40) begin
                r = 1'b0;
                w = 1'b0;
            end else begin
                r = (kind < 70) || (kind >= 95);
                w = (kind >= 70);
                if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
                else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
            end
            issue(wb, r, w, a, st, d, dly, rd);
        end
        drive_nop();
        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("plan_q_drained", plan_q.size(), 0);

        // Reset in the 2nd BUSY cycle, then a late ack that must be ignored.
        resp_en = 1'b0;
        WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        ALURes = 32'h80; STVal = 32'h0; deest = 5'd7;
        @(posedge clk);
        #1;
        check("rb_mem_req_busy", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rb_stall_in_rst", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 1'b0;
        drive_nop();
        force_ack   = 1'b1;
        force_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rb_mem_req", {31'b0, mem_req}, 32'h0);
        check("rb_mem_err", {31'b0, mem_err}, 32'h0);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        check("rb_mem_req_after_ack", {31'b0, mem_req}, 32'h0);
        check("rb_stall", {31'b0, stall}, 32'h0);
        check("rb_wb_en_out", {31'b0, WB_EN_OUT}, 32'h0);
        check("rb_mem_r_en_out", {31'b0, MEM_R_EN_OUT}, 32'h0);
        check("rb_memdata_out", MemData_OUT, 32'h0);
        check("rb_alures_out", ALURes_OUT, 32'h0);
        check("rb_dest_out", {27'b0, dest_OUT}, 32'h0);
        check("rb_mem_addr", mem_addr, 32'h0);
        check("rb_mem_wdata", mem_wdata, 32'h0);
        check("rb_mem_we", {31'b0, mem_we}, 32'h0);
        resp_en = 1'b1;

        // Controller is back in IDLE: a plain op flows through immediately.
        issue(1'b1, 1'b0, 1'b0, 32'hABCD0000, 32'h0, 5'd12, 1, 32'h0);
        check("post_rst_alures_out", ALURes_OUT, 32'hABCD0000);
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("final_exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TO_CYC, default 16, meaning BUSY cycles without mem_ack before timeout.
REQ-002 SHALL use one clock; reset is synchronous and active-high: ports clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 WB_EN, MEM_R_EN, MEM_W_EN  in  1 each  EX/MEM register controls.
REQ-006 ALURes  in  32  EX/MEM address or ALU result; STVal  in  32  store data; deest  in  5  destination register.
REQ-007 mem_req  out  1  data-memory request; mem_we  out  1  1=write, 0=read.
REQ-008 mem_addr  out  32  word address; mem_wdata  out  32  store data.
REQ-009 mem_ack  in  1  memory completion; mem_rdata  in  32  read data, valid with mem_ack.
REQ-010 stall  out  1  combinational; holds the EX/MEM register and all upstream stages.
REQ-011 WB_EN_OUT, MEM_R_EN_OUT  out  1 each; ALURes_OUT, MemData_OUT  out  32 each; dest_OUT  out  5.  Registered MEM/WB values.
REQ-012 mem_err  out  1  sticky error flag (misaligned access or timeout).

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 Access pending = MEM_R_EN|MEM_W_EN; write SHALL take priority when both are set.
REQ-015 IDLE, no access pending: each edge SHALL load the MEM/WB outputs from the inputs, with MemData_OUT <= 0; latency 1 cycle; stall=0.
REQ-016 IDLE, aligned access pending (ALURes[1:0]==0): stall=1; next edge SHALL enter BUSY, register mem_req=1, mem_we, mem_addr=ALURes and mem_wdata=STVal, and load a MEM/WB bubble (WB_EN_OUT=0, MEM_R_EN_OUT=0).
REQ-017 IDLE, misaligned access: no memory request; stall=0; mem_err set; MEM/WB SHALL capture a bubble; the instruction is dropped.
REQ-018 BUSY: stall=1; mem_req and the request fields SHALL be held stable; the cycle counter increments each cycle; MEM/WB SHALL load a bubble each edge.
REQ-019 BUSY with mem_ack sampled high: on that edge SHALL drop mem_req, buffer mem_rdata (reads only), clear the counter and enter DONE.
REQ-020 BUSY with counter==TO_CYC-1 and no ack: SHALL drop mem_req, set mem_err, buffer data 0, set the suppress flag and enter DONE.
REQ-021 DONE: stall=0 (EX/MEM still presents the same instruction).
REQ-022 DONE edge: MEM/WB SHALL load WB_EN_OUT = WB_EN & ~suppress, MEM_R_EN_OUT, ALURes_OUT and dest_OUT from the inputs, and MemData_OUT from the buffer.
REQ-023 DONE edge: FSM SHALL return to IDLE; suppress is cleared.
REQ-024 mem_ack SHALL be ignored in IDLE and DONE.
REQ-025 Read latency with zero-wait ack: MEM/WB valid 3 edges after the load first appears; each extra wait cycle adds 1.
REQ-026 Back-to-back accesses SHALL each pass through IDLE (one IDLE cycle minimum between BUSY periods).
REQ-027 mem_err SHALL stay set until reset.

Reset
REQ-028 rst high at an edge SHALL force IDLE, counter 0, suppress 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all MEM/WB outputs 0 and mem_err=0; stall reads 0 while rst is high.
REQ-029 Reset during BUSY SHALL drop mem_req at that edge; a later ack SHALL be ignored.

Verification
REQ-030 ALU op WB_EN=1, ALURes=0x10, deest=3, no memory controls -> next edge: WB_EN_OUT=1, ALURes_OUT=0x10, dest_OUT=3, stall=0.
REQ-031 Load addr 0x40, ack on the 3rd BUSY cycle with rdata 0xCAFEF00D -> stall high for 4 cycles; MemData_OUT=0xCAFEF00D and MEM_R_EN_OUT=1 one edge after DONE.
REQ-032 Store addr 0x8, STVal 0x55, ack in the 1st BUSY cycle -> mem_we=1, mem_wdata=0x55 for exactly 1 cycle; the store retires with WB_EN_OUT=0.
REQ-033 Load addr 0x41 -> no mem_req, mem_err=1, stall=0, bubble in MEM/WB.
REQ-034 Load with no ack -> mem_req high for 16 cycles then drops; mem_err=1; WB_EN_OUT=0, MemData_OUT=0.
REQ-035 rst asserted in the 2nd BUSY cycle, then ack one cycle later -> all outputs 0, FSM IDLE, no MEM/WB update from the ack.
